mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter LOW_TOP, default 8: highest valid address of the system region (0..LOW_TOP).
REQ-002 Parameter HIGH_BASE, default 2048: lowest valid address of the user region.
REQ-003 Parameter HIGH_TOP, default 2120: highest valid address of the user region.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req  input  1  CPU access request, held until accepted.
REQ-007 cpu_we  input  1  1 = write, 0 = read; sampled at accept.
REQ-008 cpu_addr  input  32  byte address; sampled at accept.
REQ-009 cpu_wdata  input  32  write data; sampled at accept.
REQ-010 cpu_ready  output  1  controller idle; a request is accepted on any edge where cpu_req and cpu_ready are both high.
REQ-011 cpu_ack  output  1  one-cycle completion pulse.
REQ-012 cpu_rdata  output  32  read data; valid while cpu_ack=1 and cpu_err=0.
REQ-013 cpu_err  output  1  error flag; qualified by cpu_ack.
REQ-014 err_count  output  8  saturating count of rejected requests.
REQ-015 mem_addr  output  32  address to main memory.
REQ-016 mem_wdata  output  32  write data to main memory.
REQ-017 mem_rd  output  1  main-memory read strobe.
REQ-018 mem_wr  output  1  main-memory write strobe.
REQ-019 mem_rdata  input  32  main-memory data out; registered, valid one edge after mem_rd.

Function
REQ-020 FSM states: IDLE, RD, RCAP, WR; cpu_ready = (state==IDLE).
REQ-021 A request is valid when cpu_addr[1:0]==0 and the address is in 0..LOW_TOP or HIGH_BASE..HIGH_TOP, inclusive on both bounds.
REQ-022 Valid accept: cpu_addr and cpu_wdata are latched into mem_addr and mem_wdata, and the FSM goes to WR if cpu_we=1, otherwise to RD.
REQ-023 Invalid accept: no memory strobe is issued, the FSM stays in IDLE, and cpu_ack=1 and cpu_err=1 are registered for the following cycle.
REQ-024 mem_rd=1 only in RD and mem_wr=1 only in WR; each is decoded from the registered state, and mem_rd and mem_wr are never high together.
REQ-025 RD moves unconditionally to RCAP.
REQ-026 RCAP: cpu_rdata<=mem_rdata and cpu_ack<=1, then the FSM returns to IDLE; read ack is high in the 3rd cycle after the accept edge.
REQ-027 WR: cpu_ack<=1 and the FSM returns to IDLE; write ack is high in the 2nd cycle after the accept edge.
REQ-028 cpu_err=0 on every valid completion; cpu_ack and cpu_err last exactly one cycle.
REQ-029 cpu_rdata holds its last value until the next read completes.
REQ-030 cpu_req while busy is ignored (no queueing); a request held through the ack cycle is accepted on that edge, giving back-to-back operation.
REQ-031 err_count increments on each invalid accept and saturates at 255.
REQ-032 mem_addr and mem_wdata hold their last latched values while IDLE.

Reset
REQ-033 While rst_n=0, regardless of clk: state=IDLE; mem_rd, mem_wr, cpu_ack and cpu_err=0; cpu_rdata, mem_addr, mem_wdata and err_count=0.
REQ-034 Reset during RD, RCAP or WR aborts the access without issuing an ack; mem_rd and mem_wr drop immediately.
REQ-035 The first accept is possible on the first rising edge after rst_n goes high.

Structure
REQ-036 Shared package mem_ctrl_pkg holds: state encodings (IDLE=2'd0, RD=2'd1, RCAP=2'd2, WR=2'd3) and the default region bounds.
REQ-037 Sub-module mem_addr_check is a combinational decoder taking address and bounds and producing addr_ok.
REQ-038 The controller connects directly to main memory: mem_addr, mem_wdata, mem_rd, mem_wr and mem_rdata map to address, data_in, rd, wr and data_out.

Verification
REQ-039 Read 2116, memory preloaded with 32'h00000001 -> mem_rd is high for exactly one cycle; ack arrives 3 cycles after accept with cpu_rdata=32'h00000001 and cpu_err=0.
REQ-040 Write 2088 with 32'h00000005, then read 2088 back-to-back -> write ack in 2 cycles, read returns 32'h00000005; the read is accepted on the write-ack edge.
REQ-041 Read 2050 (misaligned) and write 4096 (out of range) -> no mem_rd or mem_wr; each gets ack with cpu_err=1 one cycle later; err_count=2.
REQ-042 Boundary addresses 8, 2048 and 2120 are accepted; 12 and 2124 are rejected; 300 invalid requests leave err_count=255.
REQ-043 rst_n pulled low during RD of address 2048 -> mem_rd drops without waiting for clk, no ack is issued, and all outputs are 0; after release, a read of 2048 succeeds normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding,
// bus widths and the default address-region bounds.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RCAP = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam int unsigned DEF_LOW_TOP   = 8;
  localparam int unsigned DEF_HIGH_BASE = 2048;
  localparam int unsigned DEF_HIGH_TOP  = 2120;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address decoder: word-aligned and inside either the system
// region (0..low_top) or the user region (high_base..high_top), bounds inclusive.
module mem_addr_check
  import mem_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] low_top,
  input  logic [ADDR_W-1:0] high_base,
  input  logic [ADDR_W-1:0] high_top,
  output logic              addr_ok
);

  logic aligned;
  logic in_low;
  logic in_high;

  always_comb begin
    aligned = (addr[1:0] == 2'b00);
    in_low  = (addr <= low_top);
    in_high = (addr >= high_base) && (addr <= high_top);
    addr_ok = aligned && (in_low || in_high);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-main-memory access controller: validates each accepted request,
// sequences single-word reads/writes and reports completion or rejection.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LOW_TOP   = DEF_LOW_TOP,
  parameter int unsigned HIGH_BASE = DEF_HIGH_BASE,
  parameter int unsigned HIGH_TOP  = DEF_HIGH_TOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  state_t next_state;
  logic   addr_ok;
  logic   accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  mem_addr_check u_addr_check (
    .addr      (cpu_addr),
    .low_top   (ADDR_W'(LOW_TOP)),
    .high_base (ADDR_W'(HIGH_BASE)),
    .high_top  (ADDR_W'(HIGH_TOP)),
    .addr_ok   (addr_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Strobes come straight from the registered state so reset kills them at once.
  always_comb begin
    next_state = state;
    cpu_ready  = (state == IDLE);
    mem_rd     = (state == RD);
    mem_wr     = (state == WR);
    accept     = cpu_req && cpu_ready;
    case (state)
      IDLE: begin
        if (accept && addr_ok) next_state = cpu_we ? WR : RD;
      end
      RD:      next_state = RCAP;
      RCAP:    next_state = IDLE;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      err_count <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      if (accept && addr_ok) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      // Rejected requests never leave IDLE; they only report an error.
      if (accept && !addr_ok) begin
        cpu_ack   <= 1'b1;
        cpu_err   <= 1'b1;
        err_count <= sat_inc(err_count);
      end
      if (state == RCAP) begin
        cpu_rdata <= mem_rdata;
        cpu_ack   <= 1'b1;
      end
      if (state == WR) cpu_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered main-memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [7:0]  err_count;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .err_count (err_count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  // Main memory: word-addressed, output registered one edge after mem_rd.
  logic [31:0] mem [0:1023];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0]     <= 32'h1111_0000;
      mem[2]     <= 32'hA5A5_0008;
      mem[529]   <= 32'h0000_0001;
      mem_loaded <= 1'b1;
    end else begin
      if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic err, output logic [31:0] rdata,
                            output int rd_cyc, output int wr_cyc);
    int w;
    lat = 0; err = 1'b0; rdata = '0; rd_cyc = 0; wr_cyc = 0; w = 0;
    @(negedge clk);
    while (!cpu_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if (cpu_ack) begin
        lat = n; err = cpu_err; rdata = cpu_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_ec;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int lat, rdc, wrc;
    logic err;
    logic [31:0] rdata, last_rdata, last_addr, last_wdata;

    vecs[0]  = '{1'b0, 32'd2116, 32'h0,         1'b0, 32'h0000_0001, 8'd0};
    vecs[1]  = '{1'b1, 32'd2088, 32'h0000_0005, 1'b0, 32'h0,         8'd0};
    vecs[2]  = '{1'b0, 32'd2088, 32'h0,         1'b0, 32'h0000_0005, 8'd0};
    vecs[3]  = '{1'b0, 32'd2050, 32'h0,         1'b1, 32'h0,         8'd1};
    vecs[4]  = '{1'b1, 32'd4096, 32'h0000_0099, 1'b1, 32'h0,         8'd2};
    vecs[5]  = '{1'b0, 32'd8,    32'h0,         1'b0, 32'hA5A5_0008, 8'd2};
    vecs[6]  = '{1'b1, 32'd2048, 32'h1234_5678, 1'b0, 32'h0,         8'd2};
    vecs[7]  = '{1'b0, 32'd2048, 32'h0,         1'b0, 32'h1234_5678, 8'd2};
    vecs[8]  = '{1'b1, 32'd2120, 32'hCAFE_F00D, 1'b0, 32'h0,         8'd2};
    vecs[9]  = '{1'b0, 32'd2120, 32'h0,         1'b0, 32'hCAFE_F00D, 8'd2};
    vecs[10] = '{1'b0, 32'd12,   32'h0,         1'b1, 32'h0,         8'd3};
    vecs[11] = '{1'b1, 32'd2124, 32'h0000_0077, 1'b1, 32'h0,         8'd4};
    vecs[12] = '{1'b0, 32'd0,    32'h0,         1'b0, 32'h1111_0000, 8'd4};
    vecs[13] = '{1'b0, 32'd2044, 32'h0,         1'b1, 32'h0,         8'd5};
    vecs[14] = '{1'b0, 32'd9,    32'h0,         1'b1, 32'h0,         8'd6};
    vecs[15] = '{1'b1, 32'd4,    32'hDEAD_BEEF, 1'b0, 32'h0,         8'd6};
    vecs[16] = '{1'b0, 32'd4,    32'h0,         1'b0, 32'hDEAD_BEEF, 8'd6};
    vecs[17] = '{1'b1, 32'd2050, 32'h0000_0033, 1'b1, 32'h0,         8'd7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, cpu_ready}, 32'd1);
    chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rst_err", {31'b0, cpu_err}, 32'd0);
    chk("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    last_rdata = '0; last_addr = '0; last_wdata = '0;
    foreach (vecs[i]) begin
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rdata, rdc, wrc);
      if (!vecs[i].exp_err) begin
        last_addr  = vecs[i].addr;
        last_wdata = vecs[i].wdata;
        if (!vecs[i].we) last_rdata = vecs[i].exp_rdata;
      end
      chk($sformatf("v%0d_latency", i), lat,
          vecs[i].exp_err ? 32'd1 : (vecs[i].we ? 32'd2 : 32'd3));
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_rd_cycles", i), rdc,
          (!vecs[i].exp_err && !vecs[i].we) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_wr_cycles", i), wrc,
          (!vecs[i].exp_err && vecs[i].we) ? 32'd1 : 32'd0);
      if (!vecs[i].exp_err && !vecs[i].we) chk($sformatf("v%0d_ack_rdata", i), rdata, vecs[i].exp_rdata);
      @(negedge clk);
      chk($sformatf("v%0d_ack_width", i), {31'b0, cpu_ack}, 32'd0);
      chk($sformatf("v%0d_rdata_hold", i), cpu_rdata, last_rdata);
      chk($sformatf("v%0d_err_count", i), {24'b0, err_count}, {24'b0, vecs[i].exp_ec});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, last_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, last_wdata);
    end

    // Back-to-back: write, read held through the write-ack cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd2088; cpu_wdata = 32'h0000_0007;
    @(posedge clk);
    #1 cpu_we = 1'b0;
    @(negedge clk);
    chk("b2b_wr_strobe", {30'b0, mem_wr, mem_rd}, 32'd2);
    chk("b2b_busy", {30'b0, cpu_ready, cpu_ack}, 32'd0);
    @(negedge clk);
    chk("b2b_wr_ack", {29'b0, cpu_ack, cpu_err, cpu_ready}, 32'd5);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("b2b_rd_strobe", {30'b0, mem_rd, mem_wr}, 32'd2);
    @(negedge clk);
    chk("b2b_rcap", {29'b0, mem_rd, cpu_ack, cpu_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_rd_ack", {30'b0, cpu_ack, cpu_err}, 32'd2);
    chk("b2b_rd_data", cpu_rdata, 32'h0000_0007);

    // Saturation: 300 back-to-back invalid accepts
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd12;
    repeat (300) @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("sat_err_count", {24'b0, err_count}, 32'd255);

    // Reset in the middle of a read
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd2048; cpu_wdata = 32'h0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_rd_before", {31'b0, mem_rd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("abort_ack_err", {30'b0, cpu_ack, cpu_err}, 32'd0);
    chk("abort_ready", {31'b0, cpu_ready}, 32'd1);
    chk("abort_rdata", cpu_rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    chk("abort_err_count", {24'b0, err_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ack%0d", n), {31'b0, cpu_ack}, 32'd0);
    end
    run_access(1'b0, 32'd2048, 32'h0, lat, err, rdata, rdc, wrc);
    chk("post_rst_latency", lat, 32'd3);
    chk("post_rst_err", {31'b0, err}, 32'd0);
    chk("post_rst_rdata", rdata, 32'h1234_5678);
    chk("post_rst_rd_cycles", rdc, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
